// File: rtl/operand_display_seq_pkg.sv
// Shared definitions for the operand display unit: segment patterns and FSM states.
// Segment patterns are active-low with bit order {g,f,e,d,c,b,a}.
package operand_display_seq_pkg;

  localparam logic [6:0] SEG_BLANK   = 7'b1111111;
  localparam logic [6:0] SEG_MINUS   = 7'b0111111;
  localparam logic [6:0] SEG_DIGIT_0 = 7'b1000000;
  localparam logic [6:0] SEG_DIGIT_1 = 7'b1111001;
  localparam logic [6:0] SEG_DIGIT_2 = 7'b0100100;
  localparam logic [6:0] SEG_DIGIT_3 = 7'b0110000;
  localparam logic [6:0] SEG_DIGIT_4 = 7'b0011001;
  localparam logic [6:0] SEG_DIGIT_5 = 7'b0010010;
  localparam logic [6:0] SEG_DIGIT_6 = 7'b0000010;
  localparam logic [6:0] SEG_DIGIT_7 = 7'b1111000;
  localparam logic [6:0] SEG_DIGIT_8 = 7'b0000000;
  localparam logic [6:0] SEG_DIGIT_9 = 7'b0010000;

  typedef enum logic [2:0] {
    IDLE,
    ABS,
    SHIFT,
    STORE,
    DONE
  } state_t;

endpackage

// File: rtl/operand_display_seq_seg7.sv
// Combinational BCD digit to active-low 7-segment decoder; non-decimal codes show blank.
module bcd_digit_to_seg7
  import operand_display_seq_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Look up the segment pattern for one decimal digit
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_DIGIT_0;
      4'd1:    seg = SEG_DIGIT_1;
      4'd2:    seg = SEG_DIGIT_2;
      4'd3:    seg = SEG_DIGIT_3;
      4'd4:    seg = SEG_DIGIT_4;
      4'd5:    seg = SEG_DIGIT_5;
      4'd6:    seg = SEG_DIGIT_6;
      4'd7:    seg = SEG_DIGIT_7;
      4'd8:    seg = SEG_DIGIT_8;
      4'd9:    seg = SEG_DIGIT_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/operand_display_seq.sv
// Sequential operand display unit: captures N_CH signed operands, converts each in turn
// to sign plus DIGITS decimal digits with a double-dabble engine, and holds the
// resulting 7-segment patterns in registers.
module operand_display_seq
  import operand_display_seq_pkg::*;
#(
  parameter int WIDTH    = 5,
  parameter int N_CH     = 2,
  parameter int DIGITS   = 2,
  parameter int BLANK_LZ = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_CH*WIDTH-1:0]       operands,
  input  logic                        load,
  output logic                        busy,
  output logic                        done,
  output logic [N_CH*(DIGITS+1)*7-1:0] displays
);

  localparam int CHW   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CNTW  = $clog2(WIDTH + 1);
  localparam int SLOTS = DIGITS + 1;

  state_t                  state;
  state_t                  state_nxt;
  logic [N_CH*WIDTH-1:0]   shadow;
  logic [CHW-1:0]          ch;
  logic [CNTW-1:0]         cnt;
  logic                    sign;
  logic [WIDTH-1:0]        mag;
  logic [WIDTH-1:0]        cur;
  logic [DIGITS*4-1:0]     bcd;
  logic [DIGITS*4-1:0]     bcd_adj;
  logic [DIGITS*7-1:0]     digit_seg;
  logic [SLOTS*7-1:0]      chan_slots;
  logic                    lead_zero;
  logic                    last_shift;
  logic                    last_ch;

  assign cur        = shadow[ch*WIDTH +: WIDTH];
  assign last_shift = (cnt == CNTW'(WIDTH - 1));
  assign last_ch    = (ch == CHW'(N_CH - 1));

  // One decoder per digit position, shared by every channel through the converter output
  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    bcd_digit_to_seg7 u_dec (
      .bcd (bcd[g*4 +: 4]),
      .seg (digit_seg[g*7 +: 7])
    );
  end

  // State register; reset abandons any conversion in progress
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and status outputs
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (load) state_nxt = ABS;
      ABS: begin
        busy      = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_shift) state_nxt = STORE;
      end
      STORE: begin
        busy      = 1'b1;
        state_nxt = last_ch ? DONE : ABS;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Add-3 correction of every BCD nibble that would overflow on the next shift
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
  end

  // Assemble one channel's slots: digits with optional leading-zero blanking, then sign
  always_comb begin
    chan_slots = {SLOTS*7{1'b1}};
    lead_zero  = 1'b1;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      if (bcd[d*4 +: 4] != 4'd0) lead_zero = 1'b0;
      if ((BLANK_LZ != 0) && lead_zero && (d != 0)) chan_slots[d*7 +: 7] = SEG_BLANK;
      else                                          chan_slots[d*7 +: 7] = digit_seg[d*7 +: 7];
    end
    chan_slots[DIGITS*7 +: 7] = (sign && (bcd != '0)) ? SEG_MINUS : SEG_BLANK;
  end

  // Datapath: operand capture, magnitude, shift-add-3 conversion and display registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow   <= '0;
      ch       <= '0;
      cnt      <= '0;
      sign     <= 1'b0;
      mag      <= '0;
      bcd      <= '0;
      displays <= '1;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            shadow <= operands;
            ch     <= '0;
          end
        end
        ABS: begin
          sign <= cur[WIDTH-1];
          mag  <= cur[WIDTH-1] ? (~cur + WIDTH'(1)) : cur;
          bcd  <= '0;
          cnt  <= '0;
        end
        SHIFT: begin
          {bcd, mag} <= {bcd_adj, mag} << 1;
          cnt        <= cnt + CNTW'(1);
        end
        STORE: begin
          displays[ch*SLOTS*7 +: SLOTS*7] <= chan_slots;
          if (!last_ch) ch <= ch + CHW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_display_seq.sv
// Scoreboard bench for operand_display_seq: stimulus pushes expected results, per-DUT
// monitors compare them when done pulses.
module tb_operand_display_seq;

  localparam logic [6:0] SB = 7'b1111111;
  localparam logic [6:0] SM = 7'b0111111;
  localparam logic [6:0] D0 = 7'b1000000;
  localparam logic [6:0] D1 = 7'b1111001;
  localparam logic [6:0] D2 = 7'b0100100;
  localparam logic [6:0] D3 = 7'b0110000;
  localparam logic [6:0] D6 = 7'b0000010;
  localparam logic [6:0] D7 = 7'b1111000;
  localparam logic [6:0] D8 = 7'b0000000;
  localparam logic [6:0] D9 = 7'b0010000;

  typedef struct {
    logic [127:0] disp;
    int           cyc;
  } exp_t;

  logic        clk = 1'b0;
  int          cyc = 0;
  int          total = 0;
  int          passed = 0;

  logic        rst_a, load_a, busy_a, done_a;
  logic [9:0]  ops_a;
  logic [41:0] disp_a;
  logic        rst_bc, load_b, busy_b, done_b;
  logic [9:0]  ops_b;
  logic [41:0] disp_b;
  logic        load_c, busy_c, done_c;
  logic [23:0] ops_c;
  logic [83:0] disp_c;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  always #5 clk = ~clk;

  // Edge counter used to time expectations
  always @(posedge clk) cyc <= cyc + 1;

  operand_display_seq #(.WIDTH(5), .N_CH(2), .DIGITS(2), .BLANK_LZ(0)) dut_a (
    .clk(clk), .rst_n(rst_a), .operands(ops_a), .load(load_a),
    .busy(busy_a), .done(done_a), .displays(disp_a)
  );

  operand_display_seq #(.WIDTH(5), .N_CH(2), .DIGITS(2), .BLANK_LZ(1)) dut_b (
    .clk(clk), .rst_n(rst_bc), .operands(ops_b), .load(load_b),
    .busy(busy_b), .done(done_b), .displays(disp_b)
  );

  operand_display_seq #(.WIDTH(8), .N_CH(3), .DIGITS(3), .BLANK_LZ(0)) dut_c (
    .clk(clk), .rst_n(rst_bc), .operands(ops_c), .load(load_c),
    .busy(busy_c), .done(done_c), .displays(disp_c)
  );

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic [9:0] ops, input logic [127:0] exp, input bit push,
                               output int acc);
    exp_t e;
    @(posedge clk); #1;
    ops_a  = ops;
    load_a = 1'b1;
    acc    = cyc + 1;
    if (push) begin
      e.disp = exp;
      e.cyc  = acc + 14;
      q_a.push_back(e);
    end
    @(posedge clk); #1;
    load_a = 1'b0;
  endtask

  task automatic loadB(input logic [9:0] ops, input logic [127:0] exp);
    exp_t e;
    @(posedge clk); #1;
    ops_b  = ops;
    load_b = 1'b1;
    e.disp = exp;
    e.cyc  = cyc + 1 + 14;
    q_b.push_back(e);
    @(posedge clk); #1;
    load_b = 1'b0;
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_done(input int which, input string name);
    int t = 0;
    bit seen = 1'b0;
    while (!seen && t < 200) begin
      @(negedge clk);
      t++;
      case (which)
        0:       seen = done_a;
        1:       seen = done_b;
        default: seen = done_c;
      endcase
    end
    if (!seen) begin
      total++;
      $display("[TB] FAIL %s: done not seen within 200 cycles", name);
    end
  endtask

  // Monitor for DUT A: compare the scoreboard entry whenever done pulses
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (done_a) begin
      if (q_a.size() == 0) begin
        total++;
        $display("[TB] FAIL a unexpected done: got done=1 at cycle %0d expected no done", cyc);
      end else begin
        e = q_a.pop_front();
        checkOutput("a displays", 128'(disp_a), e.disp);
        checkOutput("a done cycle", 128'(cyc), 128'(e.cyc));
        checkOutput("a busy at done", 128'(busy_a), 128'(0));
      end
    end
  end

  // Monitor for DUT B
  always @(negedge clk) begin : mon_b
    exp_t e;
    if (done_b) begin
      if (q_b.size() == 0) begin
        total++;
        $display("[TB] FAIL b unexpected done: got done=1 at cycle %0d expected no done", cyc);
      end else begin
        e = q_b.pop_front();
        checkOutput("b displays", 128'(disp_b), e.disp);
        checkOutput("b done cycle", 128'(cyc), 128'(e.cyc));
      end
    end
  end

  // Monitor for DUT C
  always @(negedge clk) begin : mon_c
    exp_t e;
    if (done_c) begin
      if (q_c.size() == 0) begin
        total++;
        $display("[TB] FAIL c unexpected done: got done=1 at cycle %0d expected no done", cyc);
      end else begin
        e = q_c.pop_front();
        checkOutput("c displays", 128'(disp_c), e.disp);
        checkOutput("c done cycle", 128'(cyc), 128'(e.cyc));
      end
    end
  end

  // Watchdog so the run always terminates
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus
  initial begin
    int   a;
    exp_t e;
    rst_a  = 1'b0;
    rst_bc = 1'b0;
    load_a = 1'b0;
    load_b = 1'b0;
    load_c = 1'b0;
    ops_a  = '0;
    ops_b  = '0;
    ops_c  = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset a displays", 128'(disp_a), 128'({42{1'b1}}));
    checkOutput("reset a busy", 128'(busy_a), 128'(0));
    checkOutput("reset a done", 128'(done_a), 128'(0));
    checkOutput("reset c displays", 128'(disp_c), 128'({84{1'b1}}));
    rst_a  = 1'b1;
    rst_bc = 1'b1;

    $display("[TB] test 1: -16 / +13 with latency checks");
    applyStimulus(10'b10000_01101, 128'({SM, D1, D6, SB, D1, D3}), 1'b1, a);
    checkOutput("t1 busy cycle 1", 128'(busy_a), 128'(1));
    wait_to(a + 6);
    checkOutput("t1 ch0 before update", 128'(disp_a[20:0]), 128'({SB, SB, SB}));
    wait_to(a + 7);
    checkOutput("t1 ch0 after update", 128'(disp_a[20:0]), 128'({SB, D1, D3}));
    checkOutput("t1 ch1 holds", 128'(disp_a[41:21]), 128'({SB, SB, SB}));
    wait_to(a + 13);
    checkOutput("t1 ch1 before update", 128'(disp_a[41:21]), 128'({SB, SB, SB}));
    wait_to(a + 14);
    checkOutput("t1 ch1 after update", 128'(disp_a[41:21]), 128'({SM, D1, D6}));
    wait_done(0, "t1 done");

    $display("[TB] test 2: zero operands, no leading-zero blanking");
    applyStimulus(10'b0, 128'({SB, D0, D0, SB, D0, D0}), 1'b1, a);
    wait_done(0, "t2 done");

    $display("[TB] test 3: second load while busy is ignored");
    applyStimulus(10'b11001_01001, 128'({SM, D0, D7, SB, D0, D9}), 1'b1, a);
    wait_to(a + 4);
    ops_a  = 10'b00001_00010;
    load_a = 1'b1;
    @(posedge clk); #1;
    load_a = 1'b0;
    checkOutput("t3 busy after ignored load", 128'(busy_a), 128'(1));
    wait_done(0, "t3 done");

    $display("[TB] test 4: reset during conversion");
    applyStimulus(10'b00011_01111, 128'(0), 1'b0, a);
    wait_to(a + 8);
    rst_a = 1'b0;
    @(posedge clk); #1;
    checkOutput("t4 displays after reset", 128'(disp_a), 128'({42{1'b1}}));
    checkOutput("t4 busy after reset", 128'(busy_a), 128'(0));
    checkOutput("t4 done after reset", 128'(done_a), 128'(0));
    rst_a = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("t4 idle after reset", 128'(busy_a), 128'(0));
    applyStimulus(10'b10101_00111, 128'({SM, D1, D1, SB, D0, D7}), 1'b1, a);
    wait_done(0, "t4 fresh done");

    $display("[TB] test 6: back-to-back load after done");
    applyStimulus(10'b01010_11111, 128'({SB, D1, D0, SM, D0, D1}), 1'b1, a);
    wait_done(0, "t6 done");

    $display("[TB] test 2b: leading-zero blanking");
    loadB(10'b0, 128'({SB, SB, D0, SB, SB, D0}));
    wait_done(1, "t2b zero done");
    loadB(10'b11101_01100, 128'({SM, SB, D3, SB, D1, D2}));
    wait_done(1, "t2b mixed done");

    $display("[TB] test 5: WIDTH=8, DIGITS=3, N_CH=3");
    @(posedge clk); #1;
    ops_c  = {8'hFF, 8'h7F, 8'h80};
    load_c = 1'b1;
    e.disp = 128'({SM, D0, D0, D1, SB, D1, D2, D7, SM, D1, D2, D8});
    e.cyc  = cyc + 1 + 30;
    q_c.push_back(e);
    @(posedge clk); #1;
    load_c = 1'b0;
    wait_done(2, "t5 done");

    repeat (3) @(posedge clk);
    #1;
    checkOutput("a scoreboard drained", 128'(q_a.size()), 128'(0));
    checkOutput("b scoreboard drained", 128'(q_b.size()), 128'(0));
    checkOutput("c scoreboard drained", 128'(q_c.size()), 128'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
